// File: rtl/proc_controller_pkg.sv
// Shared opcode, state and ALU-select encodings for the lab processor control unit.
// Latency: n/a (constants only).
// Backpressure: n/a. Optional JPZ state is present only when CTRL_JPZ_EN is defined.
package ctrl_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;
    localparam logic [3:0] OP_JPZ   = 4'h6;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Codes are fixed so the board display reads the same with or without JPZ.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_ADD    = 4'd6,
        ST_SUB    = 4'd7,
`ifdef CTRL_JPZ_EN
        ST_JPZ    = 4'd8,
`endif
        ST_HALT   = 4'd9
    } state_t;

    // Sign-extend an 8-bit branch offset to 16 bits; callers keep the low PC_W bits.
    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/proc_controller_if.sv
// Bundle of instruction-memory, register-file, ALU and data-memory control signals.
// Latency: n/a (wires only).
// Backpressure: none; every attached block is always ready.
interface proc_controller_if #(
    parameter int PC_W = 7,
    parameter int N    = 4
);
    logic [15:0]     IM_data;
    logic            RF_Ra_zero;
    logic [PC_W-1:0] PC_addr;
    logic [15:0]     IR;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [N-1:0]    RF_W_addr;
    logic            RF_W_en;
    logic [N-1:0]    RF_Ra_addr;
    logic [N-1:0]    RF_Rb_addr;
    logic            RF_Ra_en;
    logic            RF_Rb_en;
    logic [1:0]      ALU_sel;
    logic            Halted;
    logic [3:0]      State;

    modport master (
        input  IM_data, RF_Ra_zero,
        output PC_addr, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_sel, Halted, State
    );

    modport slave (
        output IM_data, RF_Ra_zero,
        input  PC_addr, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, RF_Ra_en, RF_Rb_en, ALU_sel, Halted, State
    );
endinterface

// File: rtl/proc_controller_pc_counter.sv
// Program counter with async clear, sync clear, increment and add-offset load.
// Latency: new value visible one cycle after the request.
// Backpressure: none; clear has priority over increment, increment over load.
module pc_counter #(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            load_off,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // PC register; all arithmetic wraps modulo 2^PC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + ONE;
        end else if (load_off) begin
            pc <= pc + offset;
        end
    end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle control unit: fetches, decodes and sequences one instruction at a time.
// Latency: NOOP 2 cycles, ADD/SUB/STORE/JPZ 3, LOAD 4; outputs are Moore.
// Backpressure: none. Optional conditional jump enabled by CTRL_JPZ_EN.
module proc_controller
    import ctrl_pkg::*;
#(
    parameter int PC_W = 7,
    parameter int N    = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    proc_controller_if.master bus
);

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_off;
    logic [15:0]     ir_sext;
    logic            pc_clr;
    logic            pc_inc;
    logic            pc_load;

    assign ir_sext = sext8(ir[7:0]);
    assign pc_off  = ir_sext[PC_W-1:0];

    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (pc_clr),
        .inc      (pc_inc),
        .load_off (pc_load),
        .offset   (pc_off),
        .pc       (pc)
    );

`ifndef CTRL_JPZ_EN
    // Zero flag only matters for the conditional jump.
    logic unused_ra_zero;
    assign unused_ra_zero = bus.RF_Ra_zero;
`endif

    // State register; async reset makes strobes drop without waiting for a clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction register, loaded once per instruction in FETCH.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir <= '0;
        end else if (state == ST_FETCH) begin
            ir <= bus.IM_data;
        end
    end

    // Next-state, PC control and Moore output decode.
    always_comb begin
        state_nxt      = state;
        pc_clr         = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.RF_Ra_en   = 1'b0;
        bus.RF_Rb_en   = 1'b0;
        bus.ALU_sel    = ALU_PASS;
        bus.Halted     = 1'b0;

        case (state)
            ST_INIT: begin
                pc_clr    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                pc_inc    = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (ir[15:12])
                    OP_STORE: state_nxt = ST_STORE;
                    OP_LOAD:  state_nxt = ST_LOAD_A;
                    OP_ADD:   state_nxt = ST_ADD;
                    OP_SUB:   state_nxt = ST_SUB;
                    OP_HALT:  state_nxt = ST_HALT;
`ifdef CTRL_JPZ_EN
                    OP_JPZ:   state_nxt = ST_JPZ;
`endif
                    default:  state_nxt = ST_FETCH;
                endcase
            end
            ST_LOAD_A: begin
                bus.D_addr = ir[11:4];
                state_nxt  = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                bus.D_addr    = ir[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ir[3:0];
                bus.RF_W_en   = 1'b1;
                state_nxt     = ST_FETCH;
            end
            ST_STORE: begin
                bus.D_addr     = ir[7:0];
                bus.RF_Ra_addr = ir[11:8];
                bus.RF_Ra_en   = 1'b1;
                bus.D_wr       = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                bus.RF_Ra_addr = ir[11:8];
                bus.RF_Rb_addr = ir[7:4];
                bus.RF_Ra_en   = 1'b1;
                bus.RF_Rb_en   = 1'b1;
                bus.ALU_sel    = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
                bus.RF_W_addr  = ir[3:0];
                bus.RF_W_en    = 1'b1;
                state_nxt      = ST_FETCH;
            end
`ifdef CTRL_JPZ_EN
            ST_JPZ: begin
                // PC already points past the jump, so the offset is relative to that.
                bus.RF_Ra_addr = ir[11:8];
                bus.RF_Ra_en   = 1'b1;
                pc_load        = bus.RF_Ra_zero;
                state_nxt      = ST_FETCH;
            end
`endif
            ST_HALT: begin
                bus.Halted = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign bus.PC_addr = pc;
    assign bus.IR      = ir;
    assign bus.State   = state;

endmodule

// File: doc/proc_controller.md
# proc_controller

- Multi-cycle control unit for the lab processor.
- Owns the program counter (PC) and instruction register (IR).
- Fetches 16-bit instructions from the asynchronous-read instruction memory and decodes them.
- Sequences the register file read/write ports, the ALU and the data memory, one instruction at a time.
- Its read-address/enable outputs feed the register file's dual read decoder; its write outputs feed the write decoder.

## Interface
- PC_W, 7, instruction memory address width
- N, 4, register address width; fixed at 4 by the instruction format
- Clock  in  1  single clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-high; clears PC, IR and state immediately
- IM_data  in  16  instruction memory read data for the current PC_addr (combinational)
- RF_Ra_zero  in  1  register file port A data is zero (used only with CTRL_JPZ_EN)
- PC_addr  out  PC_W  current program counter
- IR  out  16  current instruction register
- D_addr  out  8  data memory address
- D_wr  out  1  data memory write strobe
- RF_s  out  1  register file write-data select: 0 = ALU, 1 = data memory
- RF_W_addr  out  N  register file write address
- RF_W_en  out  1  register file write enable
- RF_Ra_addr, RF_Rb_addr  out  N each  register file read addresses
- RF_Ra_en, RF_Rb_en  out  1 each  register file read enables
- ALU_sel  out  2  ALU operation: 00 pass A, 01 A+B, 10 A−B
- Halted  out  1  high while in HALT
- State  out  4  current state encoding, for the board display

## Operation
- Instruction format: opcode IR[15:12].
  - NOOP 0000.
  - STORE 0001: D[IR[7:0]] ← R[IR[11:8]].
  - LOAD 0010: R[IR[3:0]] ← D[IR[11:4]].
  - ADD 0011: R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]].
  - SUB 0100: R[IR[3:0]] ← R[IR[11:8]] − R[IR[7:4]].
  - HALT 0101.
  - JPZ 0110: see Configuration.
  - Any other opcode executes as NOOP.
- States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, JPZ, HALT.
- Transitions:
  - INIT → FETCH: clears PC.
  - FETCH → DECODE: IR ← IM_data; PC ← PC+1.
  - DECODE → state selected by opcode. NOOP and unknown opcodes → FETCH.
  - LOAD_A → LOAD_B.
  - LOAD_B, STORE, ADD, SUB, JPZ → FETCH.
  - HALT → HALT. Only Reset leaves HALT.
- Outputs are Moore, decoded from state and IR. In every state, any output not listed below is 0.
  - STORE: D_addr=IR[7:0], RF_Ra_addr=IR[11:8], RF_Ra_en=1, D_wr=1.
  - LOAD_A: D_addr=IR[11:4] (synchronous-read data memory).
  - LOAD_B: D_addr held; RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - ADD: both read ports enabled, addresses IR[11:8] and IR[7:4]; ALU_sel=01; RF_W_addr=IR[3:0]; RF_W_en=1; RF_s=0.
  - SUB: same as ADD with ALU_sel=10.
  - JPZ: RF_Ra_addr=IR[11:8], RF_Ra_en=1.
- PC arithmetic is modulo 2^PC_W. Increment from 2^PC_W−1 wraps to 0.

## Timing
- Reset values: state INIT, PC_addr=0, IR=0, every strobe and enable 0, Halted=0, State=INIT code.
- Cycles per instruction:
  - NOOP: 2 (FETCH, DECODE).
  - ADD, SUB, STORE, JPZ: 3.
  - LOAD: 4.
- First FETCH occurs on the cycle after Reset deasserts plus one INIT cycle.
- D_wr and RF_W_en are each high for exactly one cycle per instruction.
- Reset asserted mid-instruction drops D_wr and RF_W_en in the same cycle, without waiting for a clock edge. No partial write completes after that.

## Configuration
- CTRL_JPZ_EN defined:
  - DECODE sends opcode 0110 to JPZ.
  - In JPZ, if RF_Ra_zero=1, PC ← PC + sign-extended IR[7:0], modulo 2^PC_W, where PC is the already-incremented value.
  - If RF_Ra_zero=0, PC is unchanged.
- CTRL_JPZ_EN undefined:
  - The JPZ state is absent and opcode 0110 executes as NOOP.
  - RF_Ra_zero is ignored.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants;
  - state encoding (4-bit);
  - ALU_sel codes.
- Sub-module pc_counter (PC_W): async clear, synchronous clear, increment, load-with-offset. The controller instantiates it once.

## Test plan
- Reset, then IM returns NOOP (0x0000) → INIT, then FETCH/DECODE alternating; PC increments 0→1→2, one step per 2 cycles; all strobes stay 0.
- IR=0x3123 (ADD) → in ADD state: Ra_addr=1, Rb_addr=2, W_addr=3, ALU_sel=01, RF_W_en=1 for one cycle; PC=1 afterwards.
- IR=0x2A53 (LOAD) → LOAD_A then LOAD_B with D_addr=0xA5 in both; RF_s=1 and RF_W_en=1 in LOAD_B only; W_addr=3.
- IR=0x1507 (STORE) → D_addr=0x07, Ra_addr=5, D_wr=1 for exactly one cycle. Reset asserted in the STORE cycle → D_wr=0 immediately.
- IR=0x5000 (HALT) → Halted=1; PC frozen for 20 cycles; Reset returns to INIT with PC=0.
- With CTRL_JPZ_EN: PC=5 after fetch, IR=0x62FE, RF_Ra_zero=1 → PC=3. Same stimulus with RF_Ra_zero=0 → PC=5. With PC_W=7, PC=0x7F fetch wraps to 0.
